// File: rtl/mw_pkg.sv
// ---------------------------------------------------------------------------
// mw_pkg : shared types and helpers for the microwave cook-cycle controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mw_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COOK   = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } mw_state_t;

   function automatic int pwr_width(input int levels);
      return $clog2(levels + 1);
   endfunction

   // Saturating add on operands up to 32 bits wide, clamped to max_val.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] max_val);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/mw_tick_gen.sv
// ---------------------------------------------------------------------------
// mw_tick_gen : prescaler emitting a one-cycle tick every TICK_DIV enabled cycles
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mw_tick_gen #(
   parameter int TICK_DIV = 50000000
) (
   input  logic clk,
   input  logic resetn,
   input  logic en,
   input  logic hold,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CMAX = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          adv;

   assign adv  = en & ~hold & ~clr;
   assign tick = adv & (cnt == CMAX);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (adv) begin
         cnt <= (cnt == CMAX) ? '0 : cnt + CW'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/microwave_ctrl.sv
// ---------------------------------------------------------------------------
// microwave_ctrl : clocked cook-cycle controller (countdown, duty cycle, beep)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module microwave_ctrl
   import mw_pkg::*;
#(
   parameter int TIME_W     = 12,
   parameter int TICK_DIV   = 50000000,
   parameter int PWR_LEVELS = 10,
   parameter int BEEP_SEC   = 3,
   parameter int ADD_SEC    = 30
) (
   input  logic                              clk,
   input  logic                              resetn,
   input  logic                              door_closed,
   input  logic                              startn,
   input  logic                              stopn,
   input  logic                              clearn,
   input  logic                              load_en,
   input  logic [TIME_W-1:0]                 time_load,
   input  logic [pwr_width(PWR_LEVELS)-1:0]  power,
   output logic                              magnetron,
   output logic                              lamp,
   output logic                              beep,
   output logic                              done,
   output logic                              busy,
   output logic [TIME_W-1:0]                 time_left
);

   localparam int            PW     = pwr_width(PWR_LEVELS);
   localparam logic [PW-1:0] PMAX   = PW'(PWR_LEVELS);
   localparam logic [PW-1:0] FLAST  = PW'(PWR_LEVELS - 1);
   localparam logic [31:0]   TMAX   = 32'((64'd1 << TIME_W) - 64'd1);
   localparam int            BW     = $clog2(BEEP_SEC + 1);
   localparam logic [BW-1:0] BLAST  = BW'(BEEP_SEC - 1);

   mw_state_t         state, nstate;
   logic [TIME_W-1:0] ntime, t_add;
   logic [PW-1:0]     pwr_q, npwr, frame_q, nframe, pwr_clamped;
   logic [BW-1:0]     beep_cnt, nbeep;
   logic              done_q, ndone;
   logic              startn_q, stopn_q;
   logic              start_evt, stop_evt;
   logic              tick, tick_en, tick_hold, tick_clr;

   assign start_evt   = startn_q & ~startn;
   assign stop_evt    = stopn_q & ~stopn;
   assign pwr_clamped = (power > PMAX) ? PMAX : power;

   // Prescaler freezes on pause events so a resumed cook finishes the partial second.
   assign tick_en   = (state == ST_COOK) | (state == ST_DONE);
   assign tick_hold = ~door_closed | stop_evt;
   assign tick_clr  = ~clearn | (state == ST_IDLE);

   mw_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk    (clk),
      .resetn (resetn),
      .en     (tick_en),
      .hold   (tick_hold),
      .clr    (tick_clr),
      .tick   (tick)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         time_left <= '0;
         pwr_q     <= PMAX;
         frame_q   <= '0;
         beep_cnt  <= '0;
         done_q    <= 1'b0;
         startn_q  <= 1'b1;
         stopn_q   <= 1'b1;
      end else begin
         state     <= nstate;
         time_left <= ntime;
         pwr_q     <= npwr;
         frame_q   <= nframe;
         beep_cnt  <= nbeep;
         done_q    <= ndone;
         startn_q  <= startn;
         stopn_q   <= stopn;
      end
   end

   always_comb begin
      nstate = state;
      ntime  = time_left;
      npwr   = pwr_q;
      nframe = frame_q;
      nbeep  = beep_cnt;
      ndone  = 1'b0;
      t_add  = time_left;
      if (!clearn) begin
         nstate = ST_IDLE;
         ntime  = '0;
         nframe = '0;
         nbeep  = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (door_closed && !stop_evt) begin
                  if (start_evt) begin
                     if (stopn && (time_left != '0)) begin
                        nstate = ST_COOK;
                        nframe = '0;
                     end
                  end else if (load_en) begin
                     ntime = time_load;
                     npwr  = pwr_clamped;
                  end
               end
            end
            ST_COOK: begin
               if (!door_closed || stop_evt) begin
                  nstate = ST_PAUSED;
               end else begin
                  if (start_evt) begin
                     t_add = TIME_W'(sat_add(32'(time_left), 32'(ADD_SEC), TMAX));
                  end
                  ntime = t_add;
                  if (tick) begin
                     ntime  = t_add - TIME_W'(1);
                     nframe = (frame_q == FLAST) ? '0 : frame_q + PW'(1);
                     if (t_add == TIME_W'(1)) begin
                        nstate = ST_DONE;
                        ndone  = 1'b1;
                        nbeep  = '0;
                     end
                  end
               end
            end
            ST_PAUSED: begin
               if (door_closed) begin
                  if (stop_evt) begin
                     nstate = ST_IDLE;
                     ntime  = '0;
                  end else if (start_evt) begin
                     if (time_left != '0) begin
                        nstate = ST_COOK;
                     end
                  end else if (load_en) begin
                     ntime = time_load;
                     npwr  = pwr_clamped;
                  end
               end
            end
            ST_DONE: begin
               if (!door_closed || stop_evt || start_evt) begin
                  nstate = ST_IDLE;
                  nbeep  = '0;
               end else if (tick) begin
                  if (beep_cnt == BLAST) begin
                     nstate = ST_IDLE;
                     nbeep  = '0;
                  end else begin
                     nbeep = beep_cnt + BW'(1);
                  end
               end
            end
            default: nstate = ST_IDLE;
         endcase
      end
   end

   assign busy      = (state == ST_COOK) | (state == ST_PAUSED);
   assign beep      = (state == ST_DONE);
   assign done      = done_q;
   assign lamp      = busy | ~door_closed | (state == ST_DONE);
   assign magnetron = (state == ST_COOK) & (frame_q < pwr_q) & door_closed;

endmodule

`default_nettype wire

// File: doc/microwave_ctrl.md
Name: microwave_ctrl

Overview:
Clocked, parametrised successor to the asynchronous magnetron SR-latch controller. Owns the full cook cycle: time load, start/stop/clear, door interlock, pause/resume, seconds countdown, power-level duty cycling of the magnetron and end-of-cook beep. Sits between the debounced front-panel inputs and the magnetron/lamp/buzzer drivers.

Parameters:
TIME_W, 12, width of cook-time counter in seconds (max 2^TIME_W-1)
TICK_DIV, 50000000, clk cycles per second tick (>=2)
PWR_LEVELS, 10, number of power steps; duty frame length in seconds
BEEP_SEC, 3, beep duration in seconds after cook completes
ADD_SEC, 30, seconds added by start while cooking

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
door_closed  in  1  1 = door closed (pre-synchronised)
startn  in  1  active-low start button, level, pre-synchronised
stopn  in  1  active-low stop/pause button
clearn  in  1  active-low clear
load_en  in  1  load time_load/power (IDLE or PAUSED only)
time_load  in  TIME_W  cook time in seconds
power  in  $clog2(PWR_LEVELS+1)  power level 0..PWR_LEVELS
magnetron  out  1  magnetron enable
lamp  out  1  cavity lamp
beep  out  1  buzzer enable
done  out  1  one-cycle pulse on cook completion
busy  out  1  state is COOK or PAUSED
time_left  out  TIME_W  remaining seconds

Behaviour:
- One clock, clk; resetn synchronous active-low: on a clk edge with resetn=0 -> state IDLE, time_left=0, power reg=PWR_LEVELS, prescaler=0, frame=0, beep/done/busy=0; magnetron=0, lamp reflects door only.
- start = falling edge of startn (registered previous value, reset to 1); stop = falling edge of stopn; clearn is level.
- Priority per cycle: resetn > clearn low > door open > stop > start > load_en.
- States: IDLE, COOK, PAUSED, DONE.
- clearn=0 in any state -> IDLE, time_left=0, prescaler=0, frame=0, beep=0.
- IDLE: load_en -> time_left=time_load, power reg=min(power,PWR_LEVELS). start with door_closed, stopn=1, time_left!=0 -> COOK, frame=0, prescaler=0. start with time_left=0 or door open ignored.
- COOK: prescaler counts 0..TICK_DIV-1; wrap = second tick. On tick: time_left-1, frame = (frame==PWR_LEVELS-1)?0:frame+1. Tick that makes time_left 0 -> DONE, done=1 for that cycle. Door open or stop -> PAUSED (prescaler, frame, time_left hold). start -> time_left = min(time_left+ADD_SEC, 2^TIME_W-1) (saturating); a simultaneous tick decrement applies after the add.
- PAUSED: load_en allowed (power change takes effect on resume). start with door closed and time_left!=0 -> COOK (prescaler/frame resume). stop -> IDLE, time_left=0.
- DONE: beep=1; prescaler runs; after BEEP_SEC ticks -> IDLE. stop, start or door open -> IDLE immediately, beep=0.
- State transitions take effect 1 cycle after the sampled event edge.
- magnetron = (state==COOK) & (frame < power reg) & door_closed. The door_closed term is combinational: door open drops magnetron the same cycle, independent of the register update. Power 0 -> never on; power PWR_LEVELS -> always on.
- lamp = busy | ~door_closed | (state==DONE). busy = COOK|PAUSED.
- Loading time_load=0 leaves the controller in IDLE with time_left=0.

Decomposition:
- Package mw_pkg: state enum (IDLE, COOK, PAUSED, DONE), power-width localparam helper, saturating-add function.
- Sub-module mw_tick_gen: prescaler with enable, hold and clear inputs; outputs a one-cycle tick every TICK_DIV enabled cycles.

Test Plan:
(Bench params: TICK_DIV=4, PWR_LEVELS=10, BEEP_SEC=3, ADD_SEC=30, TIME_W=12.)
- Load 3 at power 10, door closed, start -> magnetron=1 for 12 cycles; time_left 3,2,1,0 at 4-cycle spacing; done pulses once; beep=1 for 12 cycles; then IDLE, lamp=0.
- Load 10 at power 3, start -> magnetron on for cycles 0-11 of the frame, off for 28 cycles; done after 40 cycles.
- Cooking with time_left=5 and prescaler=2, open door -> magnetron=0 same cycle, PAUSED, time_left=5. Close door and start -> COOK; next decrement 2 cycles later.
- Cooking with time_left=20, start -> 50. With time_left=4090, start -> 4095 (saturates).
- COOK with clearn=0 and startn falling in the same cycle -> IDLE, time_left=0. Start with time_left=0 -> stays IDLE. Start with door open -> stays IDLE.
- resetn=0 for one edge mid-COOK -> next cycle IDLE with all outputs at reset values. Start edge coincident with reset is ignored.
